slave_mem_responder: RTL and testbench

Memory-backed slave endpoint that consumes one slave port of the 4x4 cross bar and turns granted master requests into word reads and writes. It sits directly downstream of the cross bar, one instance per slave port (slave 0..3). It also provides programmable acknowledge wait states, so the arbiter's hold-until-ack and session-finish paths are exercised under realistic back-pressure. Reads return in order on a fixed-latency response pipeline.

---
 rtl/slave_mem_responder.sv | 150 +++++++++++++++
 tb/tb_slave_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_mem_responder.sv
// Memory-backed cross-bar slave: ack wait states plus a fixed-latency read pipeline.
// Define SLAVE_MEM_STATS_EN to add the saturating wr_cnt/rd_cnt outputs.
module slave_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WORDS    = 256,
    parameter int ACK_DELAY    = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
`ifdef SLAVE_MEM_STATS_EN
    ,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
`endif
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int L  = READ_LATENCY;
    localparam logic [3:0] CNT_LOAD =
        (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A reset landing on the ACK cycle suppresses the ack and its side effects.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (ACK_DELAY == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                ack     = ~rst;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [IW-1:0]         idx;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  unused_addr;

    assign idx         = addr[IW+1:2];
    assign wr_fire     = ack & cmd;
    assign rd_fire     = ack & ~cmd;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:IW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[idx] <= wdata;
        end
    end

    logic [L-1:0]          vld_q;
    logic [L-1:0]          v_in;
    logic [DATA_WIDTH-1:0] dat_q [L];
    logic [DATA_WIDTH-1:0] d_in  [L];

    always_comb begin
        v_in[0] = rd_fire;
        d_in[0] = mem[idx];
        for (int k = 1; k < L; k++) begin
            v_in[k] = vld_q[k-1];
            d_in[k] = dat_q[k-1];
        end
    end

    // Stages only load with valid data, so the last one holds rdata between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < L; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= v_in;
            for (int k = 0; k < L; k++) begin
                if (v_in[k]) begin
                    dat_q[k] <= d_in[k];
                end
            end
        end
    end

    assign resp  = vld_q[L-1];
    assign rdata = dat_q[L-1];

`ifdef SLAVE_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_fire && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (resp && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slave_mem_responder.sv
// Randomized bench for slave_mem_responder over three ACK_DELAY/READ_LATENCY
// configurations, checked against a transaction-level memory model.
module tb_slave_mem_responder;

    localparam int MW = 256;
    localparam int IW = 8;

    typedef enum int {
        OP_RD,
        OP_WR,
        OP_DROP,
        OP_RST
    } op_kind_e;

    typedef struct {
        op_kind_e    kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } op_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int D = (g == 1) ? 3 : 0;
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

        logic        rst, req, cmd, ack, resp;
        logic [31:0] addr, wdata, rdata;
`ifdef SLAVE_MEM_STATS_EN
        logic [15:0] wr_cnt, rd_cnt;
`endif
        logic [31:0] mem_m [MW];
        rd_t         exp_q [$];
        op_t         ops [$];
        int          wr_m, rd_m;
        bit          mon_on = 1'b0;
        bit          cfg_done = 1'b0;

        slave_mem_responder #(
            .MEM_WORDS   (MW),
            .ACK_DELAY   (D),
            .READ_LATENCY(L)
        ) dut (
            .clk   (clk),
            .rst   (rst),
            .req   (req),
            .addr  (addr),
            .cmd   (cmd),
            .wdata (wdata),
            .ack   (ack),
            .resp  (resp),
            .rdata (rdata)
`ifdef SLAVE_MEM_STATS_EN
            ,
            .wr_cnt(wr_cnt),
            .rd_cnt(rd_cnt)
`endif
        );

        initial begin : monitor
            forever begin
                @(posedge clk);
                #1;
                if (mon_on) begin
                    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                        check("resp", resp, 1'b1);
                        check("rdata", rdata, exp_q[0].data);
                        void'(exp_q.pop_front());
                        if (rd_m < 65535) rd_m++;
                    end else begin
                        check("resp_idle", resp, 1'b0);
                    end
                end
            end
        end

        initial begin : driver
            logic [31:0] a;
            op_t         op;
            int          k;
            int          idx;

            rst = 1'b1; req = 1'b0; cmd = 1'b0;
            addr = '0; wdata = '0; wr_m = 0; rd_m = 0;
            repeat (2) @(posedge clk);
            #1;
            check("rst_ack", ack, 1'b0);
            check("rst_resp", resp, 1'b0);
            check("rst_rdata", rdata, 32'h0);
            rst = 1'b0;
            mon_on = 1'b1;

            for (int i = 0; i < MW; i++) begin
                a = $urandom;
                a[IW+1:2] = i[IW-1:0];
                ops.push_back('{OP_WR, a, $urandom, 0});
            end
            ops.push_back('{OP_WR, 32'h10, 32'hDEADBEEF, 1});
            ops.push_back('{OP_RD, 32'h10, 32'h0, 0});
            ops.push_back('{OP_WR, 32'h4, 32'h11, 0});
            ops.push_back('{OP_WR, 32'h8, 32'h22, 0});
            ops.push_back('{OP_WR, 32'hC, 32'h33, 0});
            ops.push_back('{OP_RD, 32'h4, 32'h0, 0});
            ops.push_back('{OP_RD, 32'h8, 32'h0, 0});
            ops.push_back('{OP_RD, 32'hC, 32'h0, 0});
            if (D >= 3) ops.push_back('{OP_DROP, 32'h10, 32'h0, 0});
            ops.push_back('{OP_RD, 32'h10, 32'h0, 0});
            ops.push_back('{OP_WR, 32'h20, 32'h5A5A, 0});
            ops.push_back('{OP_RD, 32'h34, 32'h0, 0});
            ops.push_back('{OP_RST, 32'h20, 32'hBAD, 0});
            ops.push_back('{OP_RD, 32'h20, 32'h0, 0});
            ops.push_back('{OP_RST, 32'h20, 32'hBAD, D + 1});
            ops.push_back('{OP_RD, 32'hF000_0022, 32'h0, 0});
            for (int i = 0; i < 300; i++) begin
                op.addr = $urandom;
                op.data = $urandom;
                op.gap  = $urandom_range(0, 2);
                k = $urandom_range(0, 9);
                if (k < 5) op.kind = OP_RD;
                else if (k == 9) begin
                    op.kind = OP_RST;
                    op.gap  = $urandom_range(0, D + 1);
                end
                else if (k == 8 && D >= 3) op.kind = OP_DROP;
                else op.kind = OP_WR;
                ops.push_back(op);
            end

            foreach (ops[i]) begin
                op = ops[i];
                case (op.kind)
                    OP_RD, OP_WR: begin
                        repeat (op.gap) begin
                            @(posedge clk);
                            #1;
                            check("idle_ack", ack, 1'b0);
                        end
                        req = 1'b1; cmd = (op.kind == OP_WR);
                        addr = op.addr; wdata = op.data;
                        for (int c = 1; c <= D + 1; c++) begin
                            @(posedge clk);
                            #1;
                            check("ack_timing", ack, c == D + 1);
                        end
                        idx = int'(op.addr[IW+1:2]);
                        if (op.kind == OP_WR) begin
                            mem_m[idx] = op.data;
                            if (wr_m < 65535) wr_m++;
                        end else begin
                            exp_q.push_back('{cyc + L, mem_m[idx]});
                        end
                        @(posedge clk);
                        #1;
                        req = 1'b0;
                        check("ack_pulse", ack, 1'b0);
                    end
                    OP_DROP: begin
                        req = 1'b1; cmd = 1'b0; addr = op.addr;
                        repeat (2) begin
                            @(posedge clk);
                            #1;
                            check("drop_ack", ack, 1'b0);
                        end
                        req = 1'b0;
                        @(posedge clk);
                        #1;
                        check("drop_ack", ack, 1'b0);
                    end
                    default: begin
                        req = 1'b1; cmd = 1'b1;
                        addr = op.addr; wdata = op.data;
                        for (int c = 1; c <= op.gap; c++) begin
                            @(posedge clk);
                            #1;
                            if (c <= D) check("rst_pre_ack", ack, 1'b0);
                        end
                        rst = 1'b1;
                        while (exp_q.size() > 0 && exp_q[$].due > cyc)
                            void'(exp_q.pop_back());
                        #1;
                        check("rst_ack", ack, 1'b0);
                        @(posedge clk);
                        #1;
                        rst = 1'b0; req = 1'b0;
                        check("rst_rdata", rdata, 32'h0);
                        check("rst_ack_after", ack, 1'b0);
                        wr_m = 0; rd_m = 0;
`ifdef SLAVE_MEM_STATS_EN
                        check("rst_wr_cnt", wr_cnt, 32'h0);
                        check("rst_rd_cnt", rd_cnt, 32'h0);
`endif
                    end
                endcase
            end

            req = 1'b0;
            repeat (L + 2) begin
                @(posedge clk);
                #1;
            end
            check("drain", exp_q.size(), 32'h0);
`ifdef SLAVE_MEM_STATS_EN
            check("wr_cnt", wr_cnt, wr_m);
            check("rd_cnt", rd_cnt, rd_m);
`endif
            cfg_done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 50000; c++) begin
            @(posedge clk);
            if (g_cfg[0].cfg_done && g_cfg[1].cfg_done && g_cfg[2].cfg_done)
                break;
        end
        check("all_done",
              {g_cfg[2].cfg_done, g_cfg[1].cfg_done, g_cfg[0].cfg_done},
              32'h7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
